// File: rtl/sumador_3_lanes.sv
// sumador_3_lanes: three-stage pipelined two's-complement adder.
// The operands are cut into three lanes (LSB lane first); each pipeline
// stage adds one lane plus the carry from the stage before, so the carry
// chain in any one stage is at most one lane wide. A valid bit travels
// alongside the data. The result and overflow registers only load for
// valid slots, so they hold their last value between results.
module sumador_3_lanes #(
    parameter int WIDTH  = 11,  // operand/result width, 9..32
    parameter int LANE_W = 4    // width of lanes 0 and 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             overflow
);

    // Width of the top lane; whatever is left above lanes 0 and 1.
    localparam int L2_W = WIDTH - 2 * LANE_W;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    // valid_sr[0] = stage 1, valid_sr[1] = stage 2, valid_sr[2] = stage 3
    logic [2:0]        valid_sr;

    // Stage 1: lane0 sum and carry, untouched upper-lane operands.
    logic [LANE_W-1:0] s1_sum0;
    logic              s1_c;
    logic [LANE_W-1:0] s1_a1;
    logic [LANE_W-1:0] s1_b1;
    logic [L2_W-1:0]   s1_a2;
    logic [L2_W-1:0]   s1_b2;

    // Stage 2: lane0 and lane1 sums, carry into lane2, lane2 operands.
    logic [LANE_W-1:0] s2_sum0;
    logic [LANE_W-1:0] s2_sum1;
    logic              s2_c;
    logic [L2_W-1:0]   s2_a2;
    logic [L2_W-1:0]   s2_b2;

    // ------------------------------------------------------------------
    // Per-lane adders (combinational, one per stage)
    // ------------------------------------------------------------------
    logic [LANE_W:0]   lane0_add;  // carry-out in the top bit
    logic [LANE_W:0]   lane1_add;  // carry-out in the top bit
    logic [L2_W-1:0]   lane2_add;  // carry-out discarded: modulo 2^WIDTH
    logic              ovf_next;

    // Lane adders: lane0 has carry-in 0, lanes 1 and 2 take the registered carry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        lane0_add = '0;
        lane1_add = '0;
        lane2_add = '0;
        ovf_next  = 1'b0;

        lane0_add = {1'b0, dataa[LANE_W-1:0]} + {1'b0, datab[LANE_W-1:0]};
        lane1_add = {1'b0, s1_a1} + {1'b0, s1_b1} + (LANE_W + 1)'(s1_c);
        lane2_add = s2_a2 + s2_b2 + L2_W'(s2_c);

        // Signed overflow: operands agree in sign but the sum does not.
        ovf_next  = (s2_a2[L2_W-1] == s2_b2[L2_W-1]) &&
                    (lane2_add[L2_W-1] != s2_a2[L2_W-1]);
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    // Stage 1 register: lane0 sum/carry plus the lane1/lane2 operand bits.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, as real flops do.
        if (!rst_n) begin
            s1_sum0 <= '0;
            s1_c    <= 1'b0;
            s1_a1   <= '0;
            s1_b1   <= '0;
            s1_a2   <= '0;
            s1_b2   <= '0;
        end else begin
            s1_sum0 <= lane0_add[LANE_W-1:0];
            s1_c    <= lane0_add[LANE_W];
            s1_a1   <= dataa[2*LANE_W-1:LANE_W];
            s1_b1   <= datab[2*LANE_W-1:LANE_W];
            s1_a2   <= dataa[WIDTH-1:2*LANE_W];
            s1_b2   <= datab[WIDTH-1:2*LANE_W];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    // Stage 2 register: lane1 sum/carry, lane0 sum and lane2 operands forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum0 <= '0;
            s2_sum1 <= '0;
            s2_c    <= 1'b0;
            s2_a2   <= '0;
            s2_b2   <= '0;
        end else begin
            s2_sum0 <= s1_sum0;
            s2_sum1 <= lane1_add[LANE_W-1:0];
            s2_c    <= lane1_add[LANE_W];
            s2_a2   <= s1_a2;
            s2_b2   <= s1_b2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 (outputs)
    // ------------------------------------------------------------------
    // Output register: loads the assembled sum and overflow only for valid slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (valid_sr[1]) begin
            result   <= {lane2_add, s2_sum1, s2_sum0};
            overflow <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Valid chain
    // ------------------------------------------------------------------
    // Valid shift chain: advances every cycle, no stall; reset flushes in-flight slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[1:0], in_valid};
        end
    end

    assign out_valid = valid_sr[2];

endmodule

// File: tb/tb_sumador_3_lanes.sv
// tb_sumador_3_lanes: scoreboard bench for the three-stage lane adder.
// The driver pushes the expected result, overflow and arrival cycle when it
// issues a valid operation; the monitor pops and compares on every
// out_valid and checks that result/overflow hold between valid slots.
module tb_sumador_3_lanes;

    localparam int WIDTH  = 11;
    localparam int LANE_W = 4;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             overflow;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [WIDTH-1:0] last_res = '0;
    logic             last_ovf = 1'b0;

    sumador_3_lanes #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one slot on the next falling edge; valid slots register an expectation.
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] er, input logic eo);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        dataa    = a;
        datab    = b;
        if (v) begin
            e.res = er;
            e.ovf = eo;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Reference for the random phase: plain modulo-2^WIDTH add and sign rule.
    task automatic drive_rand(input logic v);
        logic [WIDTH-1:0] a, b, s;
        logic             o;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        s = a + b;
        o = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        drive(v, a, b, s, o);
    endtask

    // Monitor: compare each valid output against the scoreboard; check hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
                last_res <= result;
                last_ovf <= overflow;
            end else begin
                check("hold_result", 32'(result), 32'(last_res));
                check("hold_overflow", 32'(overflow), 32'(last_ovf));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dataa    = '0;
        datab    = '0;

        // Reset state
        #12;
        check("reset_result", 32'(result), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single operation, surrounded by idle slots: one out_valid pulse only
        drive(1'b1, 11'd5, 11'd5, 11'h00A, 1'b0);
        idle(5);

        // Back-to-back pair: 2 + -1, then 4 + -10
        drive(1'b1, 11'h002, 11'h7FF, 11'h001, 1'b0);
        drive(1'b1, 11'h004, 11'h7F6, 11'h7FA, 1'b0);
        idle(4);

        // Carry propagation across lane boundaries
        drive(1'b1, 11'h00F, 11'h001, 11'h010, 1'b0);
        drive(1'b1, 11'h0FF, 11'h001, 11'h100, 1'b0);
        drive(1'b1, 11'h7FF, 11'h001, 11'h000, 1'b0);
        idle(1);

        // Signed overflow boundaries
        drive(1'b1, 11'h3FF, 11'h001, 11'h400, 1'b1);
        drive(1'b1, 11'h400, 11'h7FF, 11'h3FF, 1'b1);
        drive(1'b1, 11'h400, 11'h3FF, 11'h7FF, 1'b0);
        idle(5);

        // Reset in the middle of three in-flight operations
        drive(1'b1, 11'd1, 11'd2, 11'd3, 1'b0);
        drive(1'b1, 11'd3, 11'd4, 11'd7, 1'b0);
        drive(1'b1, 11'd5, 11'd6, 11'd11, 1'b0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("midreset_result", 32'(result), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        last_res = '0;
        last_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        drive(1'b1, 11'd7, 11'd8, 11'h00F, 1'b0);
        idle(5);

        // Random operands and random valid pattern
        for (int i = 0; i < 10000; i++) drive_rand(1'($urandom_range(0, 1)));
        idle(1);

        // Bounded drain of whatever is still expected
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
